// File: rtl/lvds_pkg.sv
// lvds_pkg: shared scheduler state encoding, default sync word and width helper for the LVDS link blocks
package lvds_pkg;
    localparam logic [1:0] ST_SYNC = 2'd0, ST_ARB = 2'd1, ST_BURST = 2'd2;
    typedef enum logic [1:0] {SYNC = ST_SYNC, ARB = ST_ARB, BURST = ST_BURST} state_e;
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import lvds_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lvds_tx_scheduler.sv
// lvds_tx_scheduler: round-robin burst scheduler with sync-word insertion feeding one LVDS TX front-end
module lvds_tx_scheduler
    import lvds_pkg::*;
#(
    parameter int PARALLEL_WIDTH = 8,
    parameter int NUM_CH = 4,
    parameter int MAX_BURST = 4,
    parameter int SYNC_INTERVAL = 64,
    parameter logic [PARALLEL_WIDTH-1:0] SYNC_WORD = PARALLEL_WIDTH'(SYNC_WORD_DEFAULT),
    localparam int IW = clog2w(NUM_CH)
) (
    input  logic                             clk_sys,
    input  logic                             reset_n,
    input  logic [NUM_CH*PARALLEL_WIDTH-1:0] req_data,
    input  logic [NUM_CH-1:0]                req_valid,
    output logic [NUM_CH-1:0]                req_ready,
    input  logic [NUM_CH-1:0]                ch_enable,
    input  logic                             sync_force,
    output logic [PARALLEL_WIDTH-1:0]        out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IW-1:0]                    grant_ch,
    output logic                             sync_sent
);
    localparam int BW = clog2w(MAX_BURST + 1);
    localparam int WW = clog2w(SYNC_INTERVAL + 1);
    state_e state;
    logic sync_pend, sync_due, out_is_sync, can_load, take, arb_any;
    logic [IW-1:0] last_grant, ptr, arb_idx;
    logic [NUM_CH-1:0] arb_oh, grant_oh;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] word_cnt;
    assign ptr = (last_grant == IW'(NUM_CH - 1)) ? '0 : last_grant + 1'b1;
    assign can_load = !out_valid || out_ready;
    // ready is gated by ch_enable so a disabled channel never sees a handshake it cannot complete
    assign req_ready = (state == BURST && can_load) ? grant_oh & ch_enable : '0;
    assign take = |(req_ready & req_valid);
    assign sync_sent = out_valid && out_ready && out_is_sync;
    // interval expiry counts as due immediately so the sync lands on the burst boundary that reached it
    assign sync_due = sync_pend || word_cnt == WW'(SYNC_INTERVAL);
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req  (req_valid & ch_enable),
        .ptr  (ptr),
        .grant(arb_oh),
        .idx  (arb_idx),
        .any  (arb_any)
    );
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= SYNC;
            sync_pend <= 1'b1;
            out_is_sync <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            grant_ch <= '0;
            grant_oh <= '0;
            last_grant <= IW'(NUM_CH - 1);
            burst_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            sync_pend <= !sync_sent && (sync_due || sync_force);
            case (state)
                SYNC: begin
                    if (sync_sent) begin
                        state <= ARB;
                        word_cnt <= '0;
                    end else if (can_load) begin
                        out_data <= SYNC_WORD;
                        out_valid <= 1'b1;
                        out_is_sync <= 1'b1;
                    end
                end
                ARB: begin
                    if (sync_due) state <= SYNC;
                    else if (arb_any) begin
                        grant_ch <= arb_idx;
                        grant_oh <= arb_oh;
                        last_grant <= arb_idx;
                        burst_cnt <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (take) begin
                        out_data <= req_data[grant_ch*PARALLEL_WIDTH +: PARALLEL_WIDTH];
                        out_valid <= 1'b1;
                        out_is_sync <= 1'b0;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (word_cnt != WW'(SYNC_INTERVAL)) word_cnt <= word_cnt + 1'b1;
                        if (burst_cnt == BW'(MAX_BURST - 1)) state <= ARB;
                    end else if (can_load) state <= ARB;
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// tb_lvds_tx_scheduler: directed scoreboard bench; sources feed per-channel queues, expected words queue in order
module tb_lvds_tx_scheduler;
    localparam logic [7:0] SYNC_B = 8'hBC;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic [31:0] req_data;
    logic [3:0] req_valid, req_ready, ch_enable;
    logic sync_force, out_valid, out_ready, sync_sent;
    logic [7:0] out_data;
    logic [1:0] grant_ch;
    int checks = 0, errors = 0, acc = 0, nsync = 0, force_a = -1, force_b = -1;
    int a0, n0, n;
    logic [3:0] en = 4'hF;
    bit bp = 1'b0, sync_seen = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] src[4][$];

    lvds_tx_scheduler #(
        .PARALLEL_WIDTH(8), .NUM_CH(4), .MAX_BURST(4), .SYNC_INTERVAL(64), .SYNC_WORD(8'hBC)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .ch_enable(ch_enable), .sync_force(sync_force),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant_ch(grant_ch), .sync_sent(sync_sent)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // inputs change on the falling edge; handshakes seen here complete on the next rising edge
    task automatic cycle();
        logic [7:0] e;
        @(negedge clk_sys);
        ch_enable = en;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        sync_force = (acc == force_a) || (acc == force_b);
        for (int c = 0; c < 4; c++) begin
            req_valid[c] = src[c].size() != 0;
            if (src[c].size() != 0) req_data[c*8 +: 8] = src[c][0];
            else req_data[c*8 +: 8] = 8'h00;
        end
        #1;
        if (sync_sent) nsync++;
        if (!sync_seen) chk("rdy_before_sync", 32'(req_ready), 32'(0));
        if (exp_q.size() == 0) chk("extra_word", 32'(out_valid), 32'(0));
        else if (out_valid) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sync_sent", 32'(sync_sent), 32'(e == SYNC_B));
            if (e == SYNC_B) sync_seen = 1'b1;
        end else chk("sync_idle", 32'(sync_sent), 32'(0));
        for (int c = 0; c < 4; c++)
            if (req_valid[c] && req_ready[c]) begin
                void'(src[c].pop_front());
                acc++;
            end
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
        repeat (2) cycle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_out_data"}, 32'(out_data), 32'(0));
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_grant_ch"}, 32'(grant_ch), 32'(0));
        chk({tag, "_sync_sent"}, 32'(sync_sent), 32'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        req_data = '0;
        req_valid = '0;
        ch_enable = en;
        sync_force = 1'b0;
        out_ready = 1'b0;
        // reset release with all channels pending: sync first, then ch0,ch1,ch2,ch3,ch0 groups
        for (int k = 0; k < 8; k++) src[0].push_back(8'h20 + 8'(k));
        for (int c = 1; c < 4; c++)
            for (int k = 0; k < 4; k++) src[c].push_back(8'(16 * c + 32 + k));
        exp_q.push_back(SYNC_B);
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(16 * c + 32 + k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h24 + 8'(k));
        repeat (2) cycle();
        chk_reset("rst1");
        reset_n = 1'b1;
        drain("t2", 200);
        chk("t2_grant", 32'(grant_ch), 32'(0));
        // grant latency from idle, then fairness after wrap
        src[3].push_back(8'h60);
        src[3].push_back(8'h61);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        cycle();
        chk("t3_lat0", 32'(req_ready), 32'(0));
        cycle();
        chk("t3_lat1", 32'(req_ready), 32'(4'b1000));
        drain("t3a", 50);
        for (int k = 0; k < 4; k++) begin
            src[0].push_back(8'h70 + 8'(k));
            src[3].push_back(8'h74 + 8'(k));
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h70 + 8'(k));
        drain("t3b", 100);
        chk("t3_grant", 32'(grant_ch), 32'(3));
        // reset in the middle of a ch2 burst discards everything in flight
        for (int k = 0; k < 8; k++) begin
            src[2].push_back(8'h90 + 8'(k));
            exp_q.push_back(8'h90 + 8'(k));
        end
        repeat (5) cycle();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) src[c].delete();
        exp_q.delete();
        sync_seen = 1'b0;
        cycle();
        chk_reset("rst2");
        // ch1 streams 70 words: sync after the 64th, exactly at a burst boundary
        for (int k = 1; k <= 70; k++) src[1].push_back(8'(k));
        exp_q.push_back(SYNC_B);
        for (int k = 1; k <= 64; k++) exp_q.push_back(8'(k));
        exp_q.push_back(SYNC_B);
        for (int k = 65; k <= 70; k++) exp_q.push_back(8'(k));
        n0 = nsync;
        reset_n = 1'b1;
        drain("t4", 400);
        chk("t4_sync_pulses", 32'(nsync - n0), 32'(2));
        chk("t4_grant", 32'(grant_ch), 32'(1));
        // two forces inside the burst that also expires the interval: one sync after that burst
        a0 = acc;
        force_a = a0 + 57;
        force_b = a0 + 59;
        for (int k = 0; k < 68; k++) src[0].push_back(8'(k));
        for (int k = 0; k < 60; k++) exp_q.push_back(8'(k));
        exp_q.push_back(SYNC_B);
        for (int k = 60; k < 68; k++) exp_q.push_back(8'(k));
        n0 = nsync;
        drain("t5", 300);
        force_a = -1;
        force_b = -1;
        chk("t5_sync_pulses", 32'(nsync - n0), 32'(1));
        // random backpressure on ch2 stream
        bp = 1'b1;
        for (int k = 0; k < 16; k++) begin
            src[2].push_back(8'h10 + 8'(k));
            exp_q.push_back(8'h10 + 8'(k));
        end
        drain("t6", 300);
        bp = 1'b0;
        chk("t6_grant", 32'(grant_ch), 32'(2));
        // ch_enable drops after two accepted words; remainder held until re-enabled
        a0 = acc;
        for (int k = 0; k < 4; k++) begin
            src[3].push_back(8'hA0 + 8'(k));
            exp_q.push_back(8'hA0 + 8'(k));
        end
        n = 0;
        while (acc - a0 < 2 && n < 50) begin
            cycle();
            n++;
        end
        en = 4'b0111;
        repeat (8) cycle();
        chk("t7_src_held", 32'(src[3].size()), 32'(2));
        chk("t7_exp_left", 32'(exp_q.size()), 32'(2));
        chk("t7_no_ready", 32'(req_ready), 32'(0));
        en = 4'hF;
        drain("t7", 50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
